// File: rtl/up_mod_sync_pkg.sv
// Shared constants and types for the modulo-N up counter.
package up_mod_sync_pkg;

  // Default counter geometry used when an instance does not override it.
  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 16;

  // Width of the saturating wrap counter.
  localparam int WRAPCNT_W = 8;

  // Action chosen on a clock edge, already resolved by priority.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_CLEAR = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_COUNT = 2'd3
  } action_e;

  // True when the modulus uses the full binary range of the counter,
  // so the incrementer carry-out marks the wrap by itself.
  function automatic logic is_full_range(input int width, input int modulus);
    return (modulus == (1 << width));
  endfunction

endpackage

// File: rtl/up_mod_sync_add1_n.sv
// Combinational WIDTH-bit incrementer: Y = A + 1, Co = carry out of the MSB.
module add1_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Y,
  output logic             Co
);

  // carry[0] is the constant +1 injected at the LSB.
  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  // Half-adder ripple chain: each bit toggles when all lower bits are ones.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign Y[gi]         = A[gi] ^ carry[gi];
      assign carry[gi + 1] = A[gi] & carry[gi];
    end
  endgenerate

  assign Co = carry[WIDTH];

endmodule

// File: rtl/up_mod_sync.sv
// Modulo-N up counter with clear, parallel load, terminal count,
// one-cycle wrap pulse, saturating wrap counter and sticky load-range error.
module up_mod_sync
  import up_mod_sync_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Clear,
  input  logic                 Load,
  input  logic [WIDTH-1:0]     D,
  input  logic                 En,
  output logic [WIDTH-1:0]     Q,
  output logic                 TC,
  output logic                 Wrap,
  output logic [WRAPCNT_W-1:0] WrapCnt,
  output logic                 Err
);

  // Last legal count value and the modulus widened by one bit so that
  // MODULUS == 2^WIDTH is still representable for the load range check.
  localparam logic [WIDTH-1:0] TERM       = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH + 1)'(MODULUS);
  localparam logic             FULL_RANGE = is_full_range(WIDTH, MODULUS);

  logic [WIDTH-1:0]     q_reg, q_next;
  logic                 wrap_reg, wrap_next;
  logic [WRAPCNT_W-1:0] wrapcnt_reg, wrapcnt_next;
  logic                 err_reg, err_next;

  logic [WIDTH-1:0]     q_inc;
  logic                 q_carry;
  logic [WRAPCNT_W-1:0] wrapcnt_inc;
  logic                 wrapcnt_carry;

  logic    at_term;
  logic    wrap_hit;
  logic    load_ok;
  action_e act;

  // Count-value incrementer.
  add1_n #(
    .WIDTH(WIDTH)
  ) u_q_inc (
    .A (q_reg),
    .Y (q_inc),
    .Co(q_carry)
  );

  // Wrap-counter incrementer; its carry-out means the counter is already
  // at all ones, which is exactly the saturation condition.
  add1_n #(
    .WIDTH(WRAPCNT_W)
  ) u_wrapcnt_inc (
    .A (wrapcnt_reg),
    .Y (wrapcnt_inc),
    .Co(wrapcnt_carry)
  );

  assign at_term = (q_reg == TERM);
  assign load_ok = ({1'b0, D} < MOD_EXT);

  // With a full-range modulus the carry-out and the terminal compare are the
  // same condition; the carry is used there so the natural overflow drives it.
  assign wrap_hit = FULL_RANGE ? q_carry : at_term;

  // Resolve the per-edge action with Clear > Load > En > hold priority.
  always_comb begin
    act = ACT_HOLD;
    if (Clear) begin
      act = ACT_CLEAR;
    end else if (Load) begin
      act = ACT_LOAD;
    end else if (En) begin
      act = ACT_COUNT;
    end
  end

  // Next-state selection for count, wrap pulse, wrap counter and error flag.
  always_comb begin
    q_next       = q_reg;
    wrap_next    = 1'b0;
    wrapcnt_next = wrapcnt_reg;
    err_next     = err_reg;
    case (act)
      ACT_CLEAR: begin
        q_next       = '0;
        wrapcnt_next = '0;
        err_next     = 1'b0;
      end
      ACT_LOAD: begin
        if (load_ok) begin
          q_next = D;
        end else begin
          // Out-of-range loads park the counter at zero so Q stays legal.
          q_next   = '0;
          err_next = 1'b1;
        end
      end
      ACT_COUNT: begin
        if (wrap_hit) begin
          q_next    = '0;
          wrap_next = 1'b1;
          if (!wrapcnt_carry) begin
            wrapcnt_next = wrapcnt_inc;
          end
        end else begin
          q_next = q_inc;
        end
      end
      default: begin
        q_next = q_reg;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      q_reg       <= '0;
      wrap_reg    <= 1'b0;
      wrapcnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      q_reg       <= q_next;
      wrap_reg    <= wrap_next;
      wrapcnt_reg <= wrapcnt_next;
      err_reg     <= err_next;
    end
  end

  // TC is deliberately combinational so a cascaded stage advances on the
  // same edge on which this stage wraps.
  assign TC      = En && at_term;
  assign Q       = q_reg;
  assign Wrap    = wrap_reg;
  assign WrapCnt = wrapcnt_reg;
  assign Err     = err_reg;

endmodule

// File: tb/tb_up_mod_sync.sv
// Self-checking bench for up_mod_sync: hand table, random vs model,
// full-range saturation run, modulus-2 pulse spacing and a two-stage cascade.
module tb_up_mod_sync;

  logic CLK;
  logic rst;

  // DUT A: WIDTH=4, MODULUS=10
  logic       a_clr, a_ld, a_en;
  logic [3:0] a_d, a_q;
  logic       a_tc, a_wrap, a_err;
  logic [7:0] a_wc;

  // DUT B: WIDTH=4, MODULUS=16 (full range)
  logic       b_clr, b_ld, b_en;
  logic [3:0] b_d, b_q;
  logic       b_tc, b_wrap, b_err;
  logic [7:0] b_wc;

  // DUT E: WIDTH=1, MODULUS=2
  logic       e_clr, e_ld, e_en;
  logic [0:0] e_d, e_q;
  logic       e_tc, e_wrap, e_err;
  logic [7:0] e_wc;

  // Cascade: two MODULUS=10 stages, stage 2 enabled by stage 1 TC
  logic       c_clr, c_ld, c_en;
  logic [3:0] c_d, c1_q, c2_q;
  logic       c1_tc, c1_wrap, c1_err, c2_tc, c2_wrap, c2_err;
  logic [7:0] c1_wc, c2_wc;

  up_mod_sync #(.WIDTH(4), .MODULUS(10)) u_a (
    .CLK(CLK), .Reset(rst), .Clear(a_clr), .Load(a_ld), .D(a_d), .En(a_en),
    .Q(a_q), .TC(a_tc), .Wrap(a_wrap), .WrapCnt(a_wc), .Err(a_err));

  up_mod_sync #(.WIDTH(4), .MODULUS(16)) u_b (
    .CLK(CLK), .Reset(rst), .Clear(b_clr), .Load(b_ld), .D(b_d), .En(b_en),
    .Q(b_q), .TC(b_tc), .Wrap(b_wrap), .WrapCnt(b_wc), .Err(b_err));

  up_mod_sync #(.WIDTH(1), .MODULUS(2)) u_e (
    .CLK(CLK), .Reset(rst), .Clear(e_clr), .Load(e_ld), .D(e_d), .En(e_en),
    .Q(e_q), .TC(e_tc), .Wrap(e_wrap), .WrapCnt(e_wc), .Err(e_err));

  up_mod_sync #(.WIDTH(4), .MODULUS(10)) u_c1 (
    .CLK(CLK), .Reset(rst), .Clear(c_clr), .Load(c_ld), .D(c_d), .En(c_en),
    .Q(c1_q), .TC(c1_tc), .Wrap(c1_wrap), .WrapCnt(c1_wc), .Err(c1_err));

  up_mod_sync #(.WIDTH(4), .MODULUS(10)) u_c2 (
    .CLK(CLK), .Reset(rst), .Clear(c_clr), .Load(c_ld), .D(c_d), .En(c1_tc),
    .Q(c2_q), .TC(c2_tc), .Wrap(c2_wrap), .WrapCnt(c2_wc), .Err(c2_err));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: counter as an integer in 0..mod-1.
  typedef struct {
    int q;
    int wc;
    int err;
    int wrap;
  } mdl_t;

  function automatic mdl_t mstep(input mdl_t m, input bit clr, input bit ld,
                                 input int d, input bit en, input int mod);
    mdl_t r;
    r = m;
    r.wrap = 0;
    if (clr) begin
      r.q = 0; r.wc = 0; r.err = 0;
    end else if (ld) begin
      if (d < mod) r.q = d;
      else begin r.q = 0; r.err = 1; end
    end else if (en) begin
      r.q = (m.q + 1) % mod;
      if (r.q == 0) begin
        r.wrap = 1;
        r.wc = (m.wc < 255) ? m.wc + 1 : 255;
      end
    end
    return r;
  endfunction

  mdl_t ma, mb, me;
  mdl_t mzero = '{q: 0, wc: 0, err: 0, wrap: 0};

  // One clock on DUT A: drive, check TC before the edge, check state after.
  task automatic step_a(input bit clr, input bit ld, input int d, input bit en);
    a_clr = clr; a_ld = ld; a_d = 4'(d); a_en = en;
    #1;
    chk("a_tc", a_tc, (en && ma.q == 9) ? 1 : 0);
    @(posedge CLK); #1;
    ma = mstep(ma, clr, ld, d, en, 10);
    chk("a_q", a_q, ma.q);
    chk("a_wrap", a_wrap, ma.wrap);
    chk("a_wc", a_wc, ma.wc);
    chk("a_err", a_err, ma.err);
  endtask

  typedef struct {
    int clr, ld, d, en;
    int tc, q, wrap, wc, err;
  } vec_t;

  localparam int NV = 18;
  vec_t vt[NV];

  initial begin
    int wraps;
    int n;

    // clr ld d en | tc q wrap wc err
    vt[0]  = '{1, 0,  0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 1,  7, 0, 0, 7, 0, 0, 0};
    vt[2]  = '{0, 0,  0, 1, 0, 8, 0, 0, 0};
    vt[3]  = '{0, 0,  0, 1, 0, 9, 0, 0, 0};
    vt[4]  = '{0, 0,  0, 1, 1, 0, 1, 1, 0};
    vt[5]  = '{0, 0,  0, 1, 0, 1, 0, 1, 0};
    vt[6]  = '{0, 1, 12, 0, 0, 0, 0, 1, 1};
    vt[7]  = '{0, 0,  0, 1, 0, 1, 0, 1, 1};
    vt[8]  = '{0, 1,  9, 0, 0, 9, 0, 1, 1};
    vt[9]  = '{0, 1,  3, 1, 1, 3, 0, 1, 1};
    vt[10] = '{0, 1,  9, 0, 0, 9, 0, 1, 1};
    vt[11] = '{0, 0,  0, 0, 0, 9, 0, 1, 1};
    vt[12] = '{1, 0,  0, 1, 1, 0, 0, 0, 0};
    vt[13] = '{0, 1,  9, 0, 0, 9, 0, 0, 0};
    vt[14] = '{0, 0,  0, 1, 1, 0, 1, 1, 0};
    vt[15] = '{0, 0,  0, 0, 0, 0, 0, 1, 0};
    vt[16] = '{0, 1, 15, 1, 0, 0, 0, 1, 1};
    vt[17] = '{1, 1,  5, 1, 0, 0, 0, 0, 0};

    rst = 1'b1;
    a_clr = 0; a_ld = 0; a_d = '0; a_en = 1'b1;
    b_clr = 0; b_ld = 0; b_d = '0; b_en = 0;
    e_clr = 0; e_ld = 0; e_d = '0; e_en = 0;
    c_clr = 0; c_ld = 0; c_d = '0; c_en = 0;
    ma = mzero; mb = mzero; me = mzero;

    // Reset state, with En high to confirm reset dominates the edge.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_q", a_q, 0);
    chk("rst_tc", a_tc, 0);
    chk("rst_wrap", a_wrap, 0);
    chk("rst_wc", a_wc, 0);
    chk("rst_err", a_err, 0);
    rst = 1'b0;
    $display("reset released");

    // Count a little, then assert Reset between edges.
    for (int i = 0; i < 5; i++) step_a(0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_q", a_q, 0);
    chk("async_wc", a_wc, 0);
    @(posedge CLK); #1;
    chk("rst_hold_q", a_q, 0);
    rst = 1'b0;
    ma = mzero;
    $display("async reset mid-count");

    // 20 enabled cycles at MODULUS=10: two full passes.
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      step_a(0, 0, 0, 1);
      if (a_wrap) wraps++;
    end
    chk("run20_wraps", wraps, 2);
    chk("run20_wc", a_wc, 2);
    $display("run20: q=%0d wc=%0d wraps=%0d", a_q, a_wc, wraps);

    // Hand table on DUT A.
    for (int i = 0; i < NV; i++) begin
      a_clr = vt[i].clr[0]; a_ld = vt[i].ld[0]; a_d = 4'(vt[i].d); a_en = vt[i].en[0];
      #1;
      chk("vec_tc", a_tc, vt[i].tc);
      @(posedge CLK); #1;
      chk("vec_q", a_q, vt[i].q);
      chk("vec_wrap", a_wrap, vt[i].wrap);
      chk("vec_wc", a_wc, vt[i].wc);
      chk("vec_err", a_err, vt[i].err);
      $display("vec %0d: clr=%0d ld=%0d d=%0d en=%0d -> q=%0d wrap=%0d wc=%0d err=%0d",
               i, vt[i].clr, vt[i].ld, vt[i].d, vt[i].en, a_q, a_wrap, a_wc, a_err);
    end
    ma = mzero;

    // Random controls on DUT A against the model.
    for (int i = 0; i < 300; i++) begin
      step_a(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
             int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    $display("random A: q=%0d wc=%0d err=%0d", a_q, a_wc, a_err);
    a_en = 0; a_ld = 0; a_clr = 0;

    // MODULUS=2: Wrap high every other cycle with En held.
    e_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("e_tc", e_tc, me.q == 1 ? 1 : 0);
      @(posedge CLK); #1;
      me = mstep(me, 0, 0, 0, 1, 2);
      chk("e_q", e_q, me.q);
      chk("e_wrap", e_wrap, (i % 2 == 1) ? 1 : 0);
    end
    chk("e_wc", e_wc, 4);
    $display("mod2: wc=%0d", e_wc);
    e_en = 0;

    // Full-range 4-bit counter: natural overflow and WrapCnt saturation.
    b_en = 1'b1;
    for (int i = 0; i < 4100; i++) begin
      @(posedge CLK); #1;
      mb = mstep(mb, 0, 0, 0, 1, 16);
      chk("b_q", b_q, mb.q);
      chk("b_wrap", b_wrap, mb.wrap);
      if (i == 16 * 100 - 1) chk("b_wc_mid", b_wc, 100);
    end
    chk("b_wc_sat", b_wc, 255);
    chk("b_err", b_err, 0);
    $display("mod16 run: q=%0d wc=%0d", b_q, b_wc);
    b_en = 0;

    // Two-stage decimal cascade.
    c_en = 1'b1;
    n = 0;
    wraps = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      chk("c1_tc", c1_tc, (n % 10 == 9) ? 1 : 0);
      @(posedge CLK); #1;
      n++;
      chk("c_val", int'(c2_q) * 10 + int'(c1_q), n % 100);
      chk("c2_wrap", c2_wrap, (n % 100 == 0) ? 1 : 0);
      if (c2_wrap) wraps++;
    end
    chk("c2_wraps", wraps, 2);
    chk("c2_wc", c2_wc, 2);
    chk("c1_wc", c1_wc, 20);
    $display("cascade: value=%0d%0d c2_wc=%0d", c2_q, c1_q, c2_wc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/up_mod_sync.md
# up_mod_sync

Synchronous modulo-N up counter with enable, synchronous clear and parallel load, plus terminal-count and wrap reporting. It is the count-up counterpart to the team's 4-bit synchronous down counter. It serves as the building block for timebases, address sequencers and cascaded multi-stage counters, where one stage's TC drives the next stage's En.

## Interface
- WIDTH, 4, counter width in bits (1..16)
- MODULUS, 16, count modulus; 2 <= MODULUS <= 2^WIDTH; Q counts 0..MODULUS-1
- CLK  input  1  clock, rising-edge active
- Reset  input  1  asynchronous, active-high reset
- Clear  input  1  synchronous clear, active-high
- Load  input  1  synchronous parallel load, active-high
- D  input  WIDTH  load value
- En  input  1  count enable
- Q  output  WIDTH  current count, registered
- TC  output  1  terminal count, combinational: En && Q == MODULUS-1
- Wrap  output  1  registered one-cycle pulse, high the cycle after Q wrapped to 0
- WrapCnt  output  8  number of wraps since reset/clear, saturating at 255
- Err  output  1  sticky flag, set by a load of an out-of-range value

## Operation
- Reset is asynchronous, active-high; clock is CLK.
- While Reset is high: Q=0, Wrap=0, WrapCnt=0, Err=0. TC=0 follows from Q=0, with MODULUS>=2.
- Per-edge priority, highest first: Clear > Load > En > hold.
- Clear: Q<=0, WrapCnt<=0, Err<=0, Wrap<=0.
- Load, in range (D < MODULUS): Q<=D, Wrap<=0, WrapCnt and Err unchanged.
- Load, out of range (D >= MODULUS): Q<=0, Err<=1, Wrap<=0.
- En with Q < MODULUS-1: Q<=Q+1, Wrap<=0.
- En with Q == MODULUS-1: Q<=0, Wrap<=1, WrapCnt<=WrapCnt+1 unless already 255.
- Idle (no Clear, Load or En): Q holds, Wrap<=0.
- Increment arithmetic is WIDTH bits, unsigned. When MODULUS == 2^WIDTH, the natural carry-out wrap and the explicit compare must agree.
- Load or Clear in the same cycle as TC: the higher-priority action wins. No Wrap pulse and no WrapCnt increment occur.
- Q never holds a value >= MODULUS after any edge.

## Timing
- Q, Wrap, WrapCnt and Err update on the rising CLK edge, one cycle after the sampled control.
- TC is combinational from Q and En, with zero latency. It is intended as the next stage's En in a cascade, so the next stage advances on the same edge that this stage wraps.
- Wrap is high for exactly one cycle per wrap. Consecutive wraps (MODULUS=2, En held high) produce Wrap high on every other cycle.
- Reset assertion mid-count takes effect immediately, with no clock needed. Deassertion is synchronised externally; the first count occurs on the first edge with Reset low and En high.

## Structure
- A shared package or header holds the default WIDTH/MODULUS constants and the WrapCnt width (8).
- Sub-module add1_n: a combinational WIDTH-parameterised incrementer (Y = A+1). It is the up-counting peer of the existing subtract-by-one block.
- The top level holds the Q register, the next-state mux, the terminal compare, the range check and the Wrap/WrapCnt/Err registers.

## Test plan
- Reset mid-count, then release; En=1 for 20 cycles with WIDTH=4, MODULUS=10:
  - Q goes 0..9,0..9.
  - TC is high while Q=9.
  - Wrap pulses twice.
  - WrapCnt=2.
- Load D=7, then En=1:
  - Q=7, 8, 9, 0.
  - Wrap pulses once, in the cycle Q=0.
- Load D=12 with MODULUS=10:
  - Q=0, Err=1.
  - Err persists through counting.
  - Clear returns Q=0, Err=0, WrapCnt=0.
- At Q=9, assert En and Load (D=3) together:
  - Q=3.
  - No Wrap pulse; WrapCnt unchanged.
- With MODULUS=16, WIDTH=4, run 4100 enabled cycles:
  - Wrap and Q stay correct across the natural 4-bit overflow.
  - WrapCnt saturates at 255.
- Cascade two instances (MODULUS=10), with TC of the first driving En of the second:
  - Together they count 00..99 and wrap to 00.
  - The second stage's Wrap pulses once per 100 enabled cycles.
